// File: rtl/nds_evt_pacer.sv
// nds_evt_pacer
//
// Accepts one-cycle event requests and re-issues them as single-cycle pulses.
// Consecutive pulses are at least GAP cycles apart. Accepted events that
// are still waiting to be issued are counted in a saturating counter. When the
// counter is full and cannot drain in the same cycle, the event is dropped and
// a sticky overflow flag is set.
//
// Ports
//   a_clk      in   sole clock, rising edge
//   a_reset_n  in   asynchronous active-low reset, released on a_clk rise
//   evt_in     in   one-cycle event request (may repeat every cycle)
//   ovf_clr    in   one-cycle clear of the sticky overflow flag
//   a_pulse    out  registered paced pulse, one cycle wide
//   pending    out  registered count of accepted events not yet issued
//   overflow   out  registered sticky "event dropped" flag
//   busy       out  pending!=0, spacing in progress, or pulse in flight
module nds_evt_pacer #(
  parameter int CNT_WIDTH = 4,
  parameter int GAP       = 4
) (
  input  logic                 a_clk,
  input  logic                 a_reset_n,
  input  logic                 evt_in,
  input  logic                 ovf_clr,
  output logic                 a_pulse,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow,
  output logic                 busy
);

  // Operating mode is a pure function of pending/gap_cnt, not a stored state.
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_ISSUE = 2'd1,
    MODE_HOLD  = 2'd2
  } mode_t;

  localparam logic [CNT_WIDTH-1:0] PEND_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [7:0]           GAP_RELOAD = 8'(GAP - 1);

  mode_t      mode;
  logic [7:0] gap_cnt;
  logic       issue;
  logic       evt_acc;
  logic       evt_drop;

  // Saturating pending update: simultaneous accept and issue cancel out.
  function automatic logic [CNT_WIDTH-1:0] pend_update(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 dec
  );
    logic [CNT_WIDTH-1:0] res;
    res = cur;
    if (inc && !dec) begin
      res = (cur == PEND_MAX) ? cur : cur + 1'b1;
    end else if (dec && !inc) begin
      res = (cur == '0) ? cur : cur - 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    mode = MODE_IDLE;
    if (gap_cnt != 8'd0) begin
      mode = MODE_HOLD;
    end else if (pending != '0) begin
      mode = MODE_ISSUE;
    end
    issue    = (mode == MODE_ISSUE);
    // A full counter can still take an event when an issue frees a slot.
    evt_acc  = evt_in && ((pending != PEND_MAX) || issue);
    evt_drop = evt_in && !evt_acc;
  end

  // ---- registered state: pulse, pending count, spacing, overflow ----
  always_ff @(posedge a_clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      a_pulse  <= 1'b0;
      pending  <= '0;
      gap_cnt  <= 8'd0;
      overflow <= 1'b0;
    end else begin
      a_pulse <= issue;
      pending <= pend_update(pending, evt_acc, issue);
      if (issue) begin
        gap_cnt <= GAP_RELOAD;
      end else if (gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
      // Set has priority over clear.
      if (evt_drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign busy = (mode != MODE_IDLE) || a_pulse;

endmodule

// File: tb/tb_nds_evt_pacer.sv
module tb_nds_evt_pacer;

  logic       a_clk;
  logic       a_reset_n;
  logic       evt_in;
  logic       ovf_clr;
  logic       a_pulse;
  logic [3:0] pending;
  logic       overflow;
  logic       busy;

  logic       g1_evt_in;
  logic       g1_ovf_clr;
  logic       g1_a_pulse;
  logic [3:0] g1_pending;
  logic       g1_overflow;
  logic       g1_busy;

  int n_checks;
  int n_fail;

  nds_evt_pacer #(.CNT_WIDTH(4), .GAP(4)) dut (
    .a_clk     (a_clk),
    .a_reset_n (a_reset_n),
    .evt_in    (evt_in),
    .ovf_clr   (ovf_clr),
    .a_pulse   (a_pulse),
    .pending   (pending),
    .overflow  (overflow),
    .busy      (busy)
  );

  nds_evt_pacer #(.CNT_WIDTH(4), .GAP(1)) dut_g1 (
    .a_clk     (a_clk),
    .a_reset_n (a_reset_n),
    .evt_in    (g1_evt_in),
    .ovf_clr   (g1_ovf_clr),
    .a_pulse   (g1_a_pulse),
    .pending   (g1_pending),
    .overflow  (g1_overflow),
    .busy      (g1_busy)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle and land just after the rising edge.
  task automatic step();
    @(posedge a_clk);
    #1;
  endtask

  initial begin
    int pulse_mask;
    int peak;
    int pulses;
    int last_pulse;
    int min_space;

    n_checks   = 0;
    n_fail     = 0;
    a_reset_n  = 1'b0;
    evt_in     = 1'b0;
    ovf_clr    = 1'b0;
    g1_evt_in  = 1'b0;
    g1_ovf_clr = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_pulse", a_pulse, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);

    // Single event from idle, asserted in the release cycle
    a_reset_n = 1'b1;
    evt_in    = 1'b1;
    step();                       // cycle 1
    evt_in = 1'b0;
    chk("single_pend_c1", pending, 1);
    chk("single_pulse_c1", a_pulse, 0);
    step();                       // cycle 2
    chk("single_pulse_c2", a_pulse, 1);
    chk("single_pend_c2", pending, 0);
    step();                       // cycle 3
    chk("single_pulse_c3", a_pulse, 0);
    chk("single_busy_c3", busy, 1);
    step();                       // cycle 4
    chk("single_busy_c4", busy, 1);
    step();                       // cycle 5
    chk("single_busy_c5", busy, 0);

    // Five consecutive events: pulses at cycles 2,6,10,14,18
    pulse_mask = 0;
    peak       = 0;
    for (int c = 0; c < 25; c++) begin
      evt_in = (c < 5);
      step();
      if (a_pulse) pulse_mask |= (1 << (c + 1));
      if (int'(pending) > peak) peak = int'(pending);
    end
    evt_in = 1'b0;
    chk("burst5_pulse_mask", pulse_mask, 32'h0004_4444);
    chk("burst5_peak", peak, 4);
    chk("burst5_idle", busy, 0);

    // 24 consecutive events: saturate at 15, 3 drops (cycles 20,22,23),
    // 21 accepted. ovf_clr at 21 (issue cycle, accepted event) and at 22
    // (coincides with a dropped event).
    pulses     = 0;
    peak       = 0;
    last_pulse = -100;
    min_space  = 1000;
    for (int c = 0; c < 96; c++) begin
      evt_in  = (c < 24);
      ovf_clr = (c == 21) || (c == 22);
      step();
      if (a_pulse) begin
        pulses++;
        if ((c + 1) - last_pulse < min_space) min_space = (c + 1) - last_pulse;
        last_pulse = c + 1;
      end
      if (int'(pending) > peak) peak = int'(pending);
      if (c + 1 == 20) chk("sat_ovf_c20", overflow, 0);
      if (c + 1 == 21) chk("sat_ovf_c21", overflow, 1);
      if (c + 1 == 22) begin
        chk("sat_ovf_cleared_c22", overflow, 0);
        chk("sat_pend_c22", pending, 15);
      end
      if (c + 1 == 23) chk("sat_ovf_setwins_c23", overflow, 1);
      if (c + 1 == 24) chk("sat_ovf_c24", overflow, 1);
    end
    evt_in  = 1'b0;
    ovf_clr = 1'b0;
    chk("sat_peak", peak, 15);
    chk("sat_pulse_count", pulses, 21);
    chk("sat_min_spacing", min_space, 4);
    chk("sat_drained_pend", pending, 0);
    chk("sat_drained_busy", busy, 0);
    chk("sat_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr_alone", overflow, 0);

    // Mid-operation reset with pending=3, gap_cnt=2
    for (int c = 0; c < 7; c++) begin
      evt_in = (c < 5);
      step();
    end
    evt_in = 1'b0;
    chk("prerst_pend", pending, 3);
    chk("prerst_busy", busy, 1);
    #3;
    a_reset_n = 1'b0;
    #1;
    chk("async_rst_pulse", a_pulse, 0);
    chk("async_rst_pend", pending, 0);
    chk("async_rst_ovf", overflow, 0);
    chk("async_rst_busy", busy, 0);
    step();
    a_reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (a_pulse) pulses++;
    end
    chk("postrst_no_pulse", pulses, 0);
    chk("postrst_pend", pending, 0);

    // Event on the first edge after reset release
    a_reset_n = 1'b0;
    step();
    a_reset_n = 1'b1;
    evt_in    = 1'b1;
    step();
    evt_in = 1'b0;
    chk("rel_evt_pend", pending, 1);
    step();
    chk("rel_evt_pulse", a_pulse, 1);
    for (int c = 0; c < 6; c++) step();

    // GAP=1: four events give pulses at cycles 2..5
    pulse_mask = 0;
    peak       = 0;
    for (int c = 0; c < 10; c++) begin
      g1_evt_in = (c < 4);
      step();
      if (g1_a_pulse) pulse_mask |= (1 << (c + 1));
      if (int'(g1_pending) > peak) peak = int'(g1_pending);
    end
    g1_evt_in = 1'b0;
    chk("gap1_pulse_mask", pulse_mask, 32'h0000_003C);
    chk("gap1_peak", peak, 1);
    chk("gap1_idle", g1_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
